if_id_decode: RTL and testbench
===============================

IF_ID_DECODE -- requirements
Module: if_id_decode

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in  in  32  fetched instruction.
- pc4_in  in  32  PC+4 of the fetched instruction.
- in_valid  in  1  fetch slot holds a real instruction.
- stall  in  1  hold the current IF/ID contents.
- flush  in  1  squash the current IF/ID contents.
- instr  out  32  registered instruction.
- pc4  out  32  registered PC+4.
- valid  out  1  registered slot valid.
- RT, addi, andi, lw, sw, j, jal, jr, beq, bne  out  1 each  one-hot class lines for the control signal generator.
- illegal  out  1  valid slot with unsupported encoding.
- illegal_cnt  out  8  saturating count of illegal instructions accepted.
REQ-002 Parameter ILL_CNT_W, default 8: width of illegal_cnt.

Function
REQ-003 Register update SHALL happen on every rising clk edge, with priority flush > stall > load.
REQ-004 On flush: valid SHALL be 0 and instr SHALL be 0; pc4 holds its previous value.
REQ-005 On stall without flush: instr, pc4 and valid SHALL all hold.
REQ-006 On load: instr=instr_in, pc4=pc4_in, valid=in_valid.
REQ-007 Class lines and illegal SHALL be combinational from the registered instr and SHALL be 0 when valid=0; latency from instr_in to class lines is one cycle.
REQ-008 Decode on opcode instr[31:26]:
- 000000 with funct instr[5:0]=001000 -> jr.
- 000000 with any other funct -> RT.
- 001000 -> addi.
- 001100 -> andi.
- 100011 -> lw.
- 101011 -> sw.
- 000010 -> j.
- 000011 -> jal.
- 000100 -> beq.
- 000101 -> bne.
- any other opcode -> illegal.
REQ-009 At most one of the ten class lines and illegal SHALL be 1 in any cycle.
REQ-010 A valid all-zero instr (sll nop) SHALL decode as RT.
REQ-011 illegal_cnt SHALL increment by 1 on each clock edge where illegal=1 and stall=0 and flush=0, and SHALL saturate at 2^ILL_CNT_W-1.
REQ-012 When stall and flush are asserted together, flush SHALL win and the counter SHALL NOT increment.

Reset
REQ-013 On rst_n=0, asynchronously: instr=0, pc4=0, valid=0, illegal_cnt=0; all class lines and illegal therefore read 0.
REQ-014 Reset asserted mid-stall SHALL discard held contents; after release the first edge performs a normal load.

Structure
REQ-015 Opcode and funct encodings SHALL be constants in shared package mips_pkg, which the control signal generator also uses.
REQ-016 Decode SHALL be a combinational sub-module opcode_decoder (instr and valid in; class lines and illegal out), instantiated once; the registers and counter stay in if_id_decode.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load 0x8C820004 with in_valid=1 -> next cycle lw=1, valid=1, all other lines 0, pc4 equals pc4_in.
- Load 0x03E00008 -> jr=1, RT=0; load 0x00000000 -> RT=1.
- Load 0x20080005, assert stall for 3 cycles while instr_in changes -> addi=1 held for 3 cycles, instr=0x20080005.
- Assert stall and flush together holding an illegal opcode 0xFC000000 -> next cycle valid=0, all lines 0, illegal_cnt unchanged.
- Load 300 consecutive illegal instructions -> illegal_cnt stops at 255.
- Drop rst_n mid-stall with beq loaded -> instr=0, valid=0, beq=0 immediately, before any clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and instruction classification, used by the IF/ID
// decoder and the control signal generator.
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Instruction class. CLS_NONE covers an empty (invalid) slot.
  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_RT,
    CLS_ADDI,
    CLS_ANDI,
    CLS_LW,
    CLS_SW,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_BEQ,
    CLS_BNE,
    CLS_ILLEGAL
  } instr_class_e;

  // Map a raw instruction word onto exactly one class.
  function automatic instr_class_e classify(input logic [31:0] instr);
    instr_class_e cls;
    case (instr[31:26])
      OP_RTYPE: cls = (instr[5:0] == FUNCT_JR) ? CLS_JR : CLS_RT;
      OP_ADDI:  cls = CLS_ADDI;
      OP_ANDI:  cls = CLS_ANDI;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_BEQ:   cls = CLS_BEQ;
      OP_BNE:   cls = CLS_BNE;
      default:  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: one-hot class lines plus illegal, all zero
// for an invalid slot. Going through a single class value guarantees that at
// most one output is ever high.
module opcode_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output logic        RT,
  output logic        addi,
  output logic        andi,
  output logic        lw,
  output logic        sw,
  output logic        j,
  output logic        jal,
  output logic        jr,
  output logic        beq,
  output logic        bne,
  output logic        illegal
);

  instr_class_e cls;

  // Classify the slot; an invalid slot has no class at all.
  always_comb begin
    cls = CLS_NONE;
    if (valid) begin
      cls = classify(instr);
    end
  end

  assign RT      = (cls == CLS_RT);
  assign addi    = (cls == CLS_ADDI);
  assign andi    = (cls == CLS_ANDI);
  assign lw      = (cls == CLS_LW);
  assign sw      = (cls == CLS_SW);
  assign j       = (cls == CLS_J);
  assign jal     = (cls == CLS_JAL);
  assign jr      = (cls == CLS_JR);
  assign beq     = (cls == CLS_BEQ);
  assign bne     = (cls == CLS_BNE);
  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with flush/stall control, registered-instruction
// decode and a saturating count of illegal instructions accepted into ID.
module if_id_decode #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_in,
  input  logic [31:0]          pc4_in,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic [31:0]          instr,
  output logic [31:0]          pc4,
  output logic                 valid,
  output logic                 RT,
  output logic                 addi,
  output logic                 andi,
  output logic                 lw,
  output logic                 sw,
  output logic                 j,
  output logic                 jal,
  output logic                 jr,
  output logic                 beq,
  output logic                 bne,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  localparam logic [ILL_CNT_W-1:0] CNT_MAX = {ILL_CNT_W{1'b1}};

  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc4_q, pc4_d;
  logic                 valid_q, valid_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

  // Next IF/ID contents: flush beats stall beats load. pc4 survives a flush.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = in_valid;
    end
  end

  // Count an illegal instruction only when it actually moves on out of ID.
  always_comb begin
    cnt_d = cnt_q;
    if (illegal && !stall && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ILL_CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr       = instr_q;
  assign pc4         = pc4_q;
  assign valid       = valid_q;
  assign illegal_cnt = cnt_q;

  opcode_decoder u_opcode_decoder (
    .instr   (instr_q),
    .valid   (valid_q),
    .RT      (RT),
    .addi    (addi),
    .andi    (andi),
    .lw      (lw),
    .sw      (sw),
    .j       (j),
    .jal     (jal),
    .jr      (jr),
    .beq     (beq),
    .bne     (bne),
    .illegal (illegal)
  );

endmodule

// File: tb/tb_if_id_decode.sv
// Self-checking bench for if_id_decode: a table of single-load vectors plus
// hand-written stall, flush, saturation and reset sequences.
module tb_if_id_decode;

  // Class-line masks in the order {RT,addi,andi,lw,sw,j,jal,jr,beq,bne,illegal}
  localparam logic [10:0] M_NONE = 11'h000;
  localparam logic [10:0] M_RT   = 11'h400;
  localparam logic [10:0] M_ADDI = 11'h200;
  localparam logic [10:0] M_ANDI = 11'h100;
  localparam logic [10:0] M_LW   = 11'h080;
  localparam logic [10:0] M_SW   = 11'h040;
  localparam logic [10:0] M_J    = 11'h020;
  localparam logic [10:0] M_JAL  = 11'h010;
  localparam logic [10:0] M_JR   = 11'h008;
  localparam logic [10:0] M_BEQ  = 11'h004;
  localparam logic [10:0] M_BNE  = 11'h002;
  localparam logic [10:0] M_ILL  = 11'h001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in, pc4_in;
  logic        in_valid, stall, flush;
  logic [31:0] instr, pc4;
  logic        valid;
  logic        RT, addi, andi, lw, sw, j, jal, jr, beq, bne, illegal;
  logic [7:0]  illegal_cnt;
  logic [10:0] lines;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr_in;
    logic [31:0] pc4_in;
    logic        in_valid;
    logic [10:0] exp_lines;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  assign lines = {RT, addi, andi, lw, sw, j, jal, jr, beq, bne, illegal};

  if_id_decode #(.ILL_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .pc4_in      (pc4_in),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .instr       (instr),
    .pc4         (pc4),
    .valid       (valid),
    .RT          (RT),
    .addi        (addi),
    .andi        (andi),
    .lw          (lw),
    .sw          (sw),
    .j           (j),
    .jal         (jal),
    .jr          (jr),
    .beq         (beq),
    .bne         (bne),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present inputs on the falling edge, away from the sampling edge.
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic v,
                       input logic s, input logic f);
    @(negedge clk);
    instr_in = i;
    pc4_in   = p;
    in_valid = v;
    stall    = s;
    flush    = f;
  endtask

  // Let one rising edge happen, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'h8C820004, 32'h00400004, 1'b1, M_LW,   1'b1};
    vecs[1]  = '{32'h03E00008, 32'h00400008, 1'b1, M_JR,   1'b1};
    vecs[2]  = '{32'h00000000, 32'h0040000C, 1'b1, M_RT,   1'b1};
    vecs[3]  = '{32'h20080005, 32'h00400010, 1'b1, M_ADDI, 1'b1};
    vecs[4]  = '{32'h3108000F, 32'h00400014, 1'b1, M_ANDI, 1'b1};
    vecs[5]  = '{32'hAC820004, 32'h00400018, 1'b1, M_SW,   1'b1};
    vecs[6]  = '{32'h08100000, 32'h0040001C, 1'b1, M_J,    1'b1};
    vecs[7]  = '{32'h0C100000, 32'h00400020, 1'b1, M_JAL,  1'b1};
    vecs[8]  = '{32'h10850003, 32'h00400024, 1'b1, M_BEQ,  1'b1};
    vecs[9]  = '{32'h14850003, 32'h00400028, 1'b1, M_BNE,  1'b1};
    vecs[10] = '{32'hFC000000, 32'h0040002C, 1'b1, M_ILL,  1'b1};
    vecs[11] = '{32'h8C820004, 32'h00400030, 1'b0, M_NONE, 1'b0};
    vecs[12] = '{32'h00221820, 32'h00400034, 1'b1, M_RT,   1'b1};

    // Reset held across clock edges with live-looking inputs.
    rst_n    = 1'b0;
    instr_in = 32'h8C820004;
    pc4_in   = 32'h12345678;
    in_valid = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_instr", instr, 32'h0);
    check("reset_pc4", pc4, 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_lines", 32'(lines), 32'(M_NONE));
    check("reset_cnt", 32'(illegal_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one plain load per vector, decoded one cycle later.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].instr_in, vecs[i].pc4_in, vecs[i].in_valid, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_lines", i), 32'(lines), 32'(vecs[i].exp_lines));
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_instr", i), instr, vecs[i].instr_in);
      check($sformatf("vec%0d_pc4", i), pc4, vecs[i].pc4_in);
    end
    // Only vec10 was illegal, and it left ID on the vec11 edge.
    check("cnt_after_table", 32'(illegal_cnt), 32'd1);

    // Stall holds addi for three cycles while instr_in keeps changing.
    do_reset();
    drive(32'h20080005, 32'h00000104, 1'b1, 1'b0, 1'b0);
    tick();
    check("stall_load_addi", 32'(lines), 32'(M_ADDI));
    for (int k = 0; k < 3; k++) begin
      drive(32'h8C820004 + 32'(k), 32'h00000200 + 32'(k), 1'b1, 1'b1, 1'b0);
      tick();
      check($sformatf("stall%0d_lines", k), 32'(lines), 32'(M_ADDI));
      check($sformatf("stall%0d_instr", k), instr, 32'h20080005);
      check($sformatf("stall%0d_pc4", k), pc4, 32'h00000104);
    end
    drive(32'h8C820004, 32'h00000108, 1'b1, 1'b0, 1'b0);
    tick();
    check("unstall_lw", 32'(lines), 32'(M_LW));

    // Stall and flush together on an illegal opcode: flush wins, no count.
    do_reset();
    drive(32'hFC000000, 32'h00000300, 1'b1, 1'b0, 1'b0);
    tick();
    check("sf_load_illegal", 32'(lines), 32'(M_ILL));
    drive(32'h8C820004, 32'h00000304, 1'b1, 1'b1, 1'b1);
    tick();
    check("sf_valid", 32'(valid), 32'h0);
    check("sf_instr", instr, 32'h0);
    check("sf_lines", 32'(lines), 32'(M_NONE));
    check("sf_pc4_held", pc4, 32'h00000300);
    check("sf_cnt", 32'(illegal_cnt), 32'h0);

    // Stall alone on an illegal opcode does not count; the release edge does.
    drive(32'hFC000000, 32'h00000308, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h00000000, 32'h0000030C, 1'b1, 1'b1, 1'b0);
    tick();
    check("stall_ill_lines", 32'(lines), 32'(M_ILL));
    check("stall_ill_cnt", 32'(illegal_cnt), 32'h0);
    drive(32'h00000000, 32'h00000310, 1'b1, 1'b0, 1'b0);
    tick();
    check("release_ill_cnt", 32'(illegal_cnt), 32'h1);
    check("release_nop_rt", 32'(lines), 32'(M_RT));

    // Flush alone squashes jr and keeps pc4.
    drive(32'h03E00008, 32'h00000314, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h20080005, 32'h00000318, 1'b1, 1'b0, 1'b1);
    tick();
    check("flush_lines", 32'(lines), 32'(M_NONE));
    check("flush_instr", instr, 32'h0);
    check("flush_pc4_held", pc4, 32'h00000314);

    // 300 back-to-back illegal loads: count lags by one and saturates at 255.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      drive(32'hFC000000 + 32'(k), 32'h00001000 + 32'(k), 1'b1, 1'b0, 1'b0);
      tick();
      if (k == 255) check("sat_cnt_254", 32'(illegal_cnt), 32'd254);
      if (k == 256) check("sat_cnt_255", 32'(illegal_cnt), 32'd255);
    end
    check("sat_cnt_final", 32'(illegal_cnt), 32'd255);

    // Reset dropped mid-stall with beq held clears outputs before any edge.
    do_reset();
    drive(32'h10850003, 32'h00000400, 1'b1, 1'b0, 1'b0);
    tick();
    check("rst_beq_loaded", 32'(lines), 32'(M_BEQ));
    drive(32'h8C820004, 32'h00000404, 1'b1, 1'b1, 1'b0);
    tick();
    check("rst_beq_stalled", 32'(lines), 32'(M_BEQ));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_instr", instr, 32'h0);
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_beq", 32'(beq), 32'h0);
    check("async_rst_pc4", pc4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h8C820004, 32'h00000408, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_lw", 32'(lines), 32'(M_LW));
    check("post_rst_pc4", pc4, 32'h00000408);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
